kem_sequencer: RTL and testbench
================================

KEM_SEQUENCER -- requirements
Module: kem_sequencer

Interface
REQ-001 The block SHALL have parameter K, default ML_KEM_K (2), giving the module-lattice rank, legal range 2..4.
REQ-002 The block SHALL have parameter TIMEOUT, default 4096, giving the maximum cycles to wait for any module done, legal range 16..65535.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start_i  input  1  one-cycle request to run one operation.
REQ-006 mode_i  input  3  kem_mode_t {keygen, encap, decap}, sampled only in the cycle start_i is accepted.
REQ-007 done_i  input  5  kem_module_t {trng, sampleA, sampleCBD_2k, ntt, hashG}; one-cycle completion pulses from the datapath modules.
REQ-008 go_o  output  5  kem_module_t; one-hot, one-cycle start pulse to the selected module.
REQ-009 idx_o  output  4  iteration index of the current step, held stable from go_o until the matching done_i.
REQ-010 busy_o  output  1  high while an operation is in progress.
REQ-011 done_o  output  1  one-cycle pulse on successful completion.
REQ-012 err_o  output  2  error code: 0 none, 1 illegal mode, 2 timeout, 3 unexpected done; held until the next accepted start_i.

Function
REQ-013 The controller SHALL step through the states IDLE, TRNG, HASHG1, SAMPLEA, CBD, NTT, HASHG2, FINISH, ABORT.
REQ-014 Each stage SHALL run as an ISSUE/WAIT pair:
  - ISSUE asserts go_o for exactly one cycle.
  - WAIT holds until the matching done_i bit is seen.
REQ-015 Stage order and iteration counts by mode SHALL be:
  - keygen: TRNG x1, HASHG1 x1, SAMPLEA x K*K, CBD x 2K, NTT x 2K.
  - encap: TRNG x1, HASHG1 x1, SAMPLEA x K*K, CBD x (2K+1), NTT x K.
  - decap: HASHG1 x1, SAMPLEA x K*K, CBD x (2K+1), NTT x K, HASHG2 x1.
REQ-016 idx_o SHALL be 0 on entry to each stage and increment by 1 after each matching done_i; in SAMPLEA idx_o = i*K+j, with j varying fastest.
REQ-017 start_i SHALL be accepted only in IDLE; in all other states it SHALL be ignored.
REQ-018 Acceptance timing SHALL be: start accepted in cycle N, busy_o high from N+1, first go_o in N+1.
REQ-019 After the matching done_i in cycle M, the next go_o (same or next stage) SHALL be asserted in cycle M+1.
REQ-020 After the last done_i of the last stage in cycle M:
  - FINISH SHALL assert done_o in cycle M+1.
  - busy_o SHALL go low in M+1.
  - The controller SHALL return to IDLE.
REQ-021 If mode_i is not one-hot at acceptance:
  - no go_o SHALL be issued;
  - err_o=1 SHALL be set in N+1;
  - busy_o SHALL stay low;
  - the controller SHALL stay in IDLE.
REQ-022 A 16-bit wait counter SHALL clear on every go_o and increment each WAIT cycle. When it reaches TIMEOUT-1 without the matching done_i, the block SHALL enter ABORT with err_o=2.
REQ-023 ABORT SHALL also be entered with err_o=3 if, while busy_o is high:
  - any non-matching done_i bit is set, or
  - any done_i bit is set during an ISSUE cycle.
REQ-024 A matching and a non-matching done_i in the same cycle SHALL be treated as an error (err_o=3).
REQ-025 ABORT SHALL last one cycle, drop busy_o, issue no done_o, and return to IDLE.
REQ-026 done_i bits asserted while in IDLE SHALL be ignored.
REQ-027 A start_i accepted in IDLE SHALL clear err_o, with the new value visible in N+1.
REQ-028 go_o SHALL never have more than one bit set.

Reset
REQ-029 On rst high, asynchronously:
  - the state SHALL go to IDLE;
  - go_o=0, idx_o=0, busy_o=0, done_o=0, err_o=0;
  - the wait counter SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL abort without a done_o pulse. After rst falls, the first start_i SHALL be accepted no earlier than the first rising edge with rst low.

Verification
REQ-031 Keygen, K=2, each module returns done 3 cycles after its go_o:
  - required go_o pulse counts: trng 1, hashG 1, sampleA 4 (idx 0..3), sampleCBD_2k 4, ntt 4;
  - exactly one done_o; err_o=0;
  - busy_o high for exactly 14*4=56 cycles.
REQ-032 Decap, K=2, same responder:
  - go_o order: hashG, sampleA x4, sampleCBD_2k x5, ntt x2, hashG;
  - done_o one cycle after the final hashG done.
REQ-033 Illegal mode: start_i with mode_i=3'b110 -> err_o=1 in the next cycle; no go_o; busy_o stays 0. A following legal start clears err_o.
REQ-034 Timeout: TIMEOUT=16, the ntt responder is silent -> err_o=2 exactly 16 cycles after the first ntt go_o; busy_o=0; no done_o.
REQ-035 Unexpected done: during sampleA WAIT, pulse done_i.ntt -> err_o=3 next cycle and the controller returns to IDLE. A start_i pulsed while busy is ignored, with no change to the go_o sequence.
REQ-036 Reset mid-run: assert rst during CBD idx 2 -> all outputs 0 immediately. A new encap run afterwards completes normally with counts trng 1, hashG 1, sampleA 4, sampleCBD_2k 5, ntt 2.

Source files
------------

// File: rtl/kem_sequencer.sv
// kem_sequencer: steps ML-KEM keygen/encap/decap through the datapath modules as ISSUE/WAIT pairs
module kem_sequencer #(
  parameter int K       = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [2:0] mode_i,
  input  logic [4:0] done_i,
  output logic [4:0] go_o,
  output logic [3:0] idx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] err_o
);
  typedef enum logic [3:0] {IDLE, TRNG, HASHG1, SAMPLEA, CBD, NTT, HASHG2, FINISH, ABORT} state_t;
  localparam logic [3:0]  L_SA     = 4'(K * K - 1);
  localparam logic [3:0]  L_CBD_KG = 4'(2 * K - 1);
  localparam logic [3:0]  L_CBD    = 4'(2 * K);
  localparam logic [3:0]  L_NTT_KG = 4'(2 * K - 1);
  localparam logic [3:0]  L_NTT    = 4'(K - 1);
  localparam logic [15:0] L_TO     = 16'(TIMEOUT - 1);
  state_t      r_state, w_state, w_nxt_stage;
  logic        r_wait, w_wait;
  logic [3:0]  r_idx, w_idx, w_last;
  logic [15:0] r_cnt, w_cnt, w_cnt_inc;
  logic [1:0]  r_err, w_err;
  logic        r_keygen, w_keygen, r_decap, w_decap;
  logic [4:0]  w_mod, w_match, w_other;
  logic        w_stage, w_legal;
  assign w_mod = (r_state == TRNG)    ? 5'b00001 :
                 (r_state == SAMPLEA) ? 5'b00010 :
                 (r_state == CBD)     ? 5'b00100 :
                 (r_state == NTT)     ? 5'b01000 :
                 (r_state == HASHG1 || r_state == HASHG2) ? 5'b10000 : 5'b00000;
  assign w_last = (r_state == SAMPLEA) ? L_SA :
                  (r_state == CBD)     ? (r_keygen ? L_CBD_KG : L_CBD) :
                  (r_state == NTT)     ? (r_keygen ? L_NTT_KG : L_NTT) : 4'd0;
  assign w_nxt_stage = (r_state == TRNG)    ? HASHG1 :
                       (r_state == HASHG1)  ? SAMPLEA :
                       (r_state == SAMPLEA) ? CBD :
                       (r_state == CBD)     ? NTT :
                       (r_state == NTT && r_decap) ? HASHG2 : FINISH;
  assign w_stage   = |w_mod;
  assign w_match   = done_i & w_mod;
  assign w_other   = done_i & ~w_mod;
  assign w_legal   = (|mode_i) && ~|(mode_i & (mode_i - 3'd1));
  assign w_cnt_inc = r_cnt + 16'd1;
  assign go_o      = (w_stage && !r_wait) ? w_mod : 5'b00000;
  assign busy_o    = w_stage;
  assign done_o    = (r_state == FINISH);
  assign idx_o     = r_idx;
  assign err_o     = r_err;
  // next-state: accept/reject start, advance stages on matching done, abort on stray done or timeout
  always_comb begin
    w_state  = r_state;
    w_wait   = r_wait;
    w_idx    = r_idx;
    w_cnt    = r_cnt;
    w_err    = r_err;
    w_keygen = r_keygen;
    w_decap  = r_decap;
    if (r_state == IDLE) begin
      if (start_i && w_legal) begin
        w_err    = 2'd0;
        w_keygen = mode_i[0];
        w_decap  = mode_i[2];
        w_state  = mode_i[2] ? HASHG1 : TRNG;
        w_wait   = 1'b0;
        w_idx    = 4'd0;
        w_cnt    = 16'd0;
      end else if (start_i) begin
        w_err = 2'd1;
      end
    end else if (w_stage) begin
      if (!r_wait) begin
        w_state = |done_i ? ABORT : r_state;
        w_err   = |done_i ? 2'd3 : r_err;
        w_wait  = 1'b1;
        w_cnt   = 16'd0;
      end else if (|w_other) begin
        w_state = ABORT;
        w_err   = 2'd3;
      end else if (|w_match) begin
        w_wait  = 1'b0;
        w_state = (r_idx == w_last) ? w_nxt_stage : r_state;
        w_idx   = (r_idx == w_last) ? 4'd0 : r_idx + 4'd1;
      end else if (w_cnt_inc == L_TO) begin
        w_state = ABORT;
        w_err   = 2'd2;
      end else begin
        w_cnt = w_cnt_inc;
      end
    end else begin
      w_state = IDLE;
      w_wait  = 1'b0;
      w_idx   = 4'd0;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wait   <= 1'b0;
      r_idx    <= 4'd0;
      r_cnt    <= 16'd0;
      r_err    <= 2'd0;
      r_keygen <= 1'b0;
      r_decap  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_wait   <= w_wait;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      r_err    <= w_err;
      r_keygen <= w_keygen;
      r_decap  <= w_decap;
    end
  end
endmodule

// File: tb/tb_kem_sequencer.sv
// tb_kem_sequencer: scoreboard and vector-table bench for kem_sequencer with a 3-cycle responder
module tb_kem_sequencer;
  localparam int K = 2;
  logic       clk = 1'b0;
  logic       rst, start_i;
  logic [2:0] mode_i;
  logic [4:0] done_i, go_o;
  logic [3:0] idx_o;
  logic       busy_o, done_o;
  logic [1:0] err_o;
  logic [4:0] p1, p2, p3, silent, inj;
  typedef struct {logic [4:0] go; int idx;} step_t;
  typedef struct {string name; logic [2:0] mode; int g0, g1, g2, g3, g4, busy;} vec_t;
  step_t exp_q[$];
  step_t mon_s;
  vec_t  vt[3];
  int checks = 0, errors = 0, cyc = 0;
  int n_go[5];
  int n_busy, n_done, start_cyc, last_done_cyc, ntt_go_cyc;
  bit first_pend = 1'b0;

  kem_sequencer #(.K(K), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .done_i(done_i),
    .go_o(go_o), .idx_o(idx_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // responder: every module answers 3 cycles after its go unless silenced
  assign done_i = p3 | inj;
  always @(posedge clk or posedge rst)
    if (rst) begin p1 <= '0; p2 <= '0; p3 <= '0; end
    else begin p1 <= go_o & ~silent; p2 <= p1; p3 <= p2; end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [4:0] g, input int i);
    step_t s;
    s.go = g; s.idx = i;
    exp_q.push_back(s);
  endtask

  // reference go sequence for one operation
  task automatic push_seq(input logic [2:0] m);
    if (!m[2]) push(5'b00001, 0);
    push(5'b10000, 0);
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) push(5'b00010, i * K + j);
    for (int i = 0; i < (m[0] ? 2 * K : 2 * K + 1); i++) push(5'b00100, i);
    for (int i = 0; i < (m[0] ? 2 * K : K); i++) push(5'b01000, i);
    if (m[2]) push(5'b10000, 0);
  endtask

  task automatic clear_stats();
    foreach (n_go[b]) n_go[b] = 0;
    n_busy = 0; n_done = 0; ntt_go_cyc = -1;
  endtask

  task automatic pulse_start(input logic [2:0] m, input bit legal);
    @(negedge clk);
    mode_i = m; start_i = 1'b1;
    if (legal) begin start_cyc = cyc; first_pend = 1'b1; end
    @(negedge clk);
    start_i = 1'b0; mode_i = 3'b000;
  endtask

  task automatic wait_end(input string name);
    int t;
    for (t = 0; t < 2000 && n_done == 0 && err_o == 2'd0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({name, "_completed"}, n_done, 1);
    chk({name, "_err"}, int'(err_o), 0);
    chk({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  // monitor: pops the scoreboard on each go and tracks latencies and pulse counts
  always @(negedge clk) if (!rst) begin
    if (busy_o) n_busy++;
    if (done_i != 5'b0) last_done_cyc = cyc;
    if (done_o) begin
      n_done++;
      chk("done_latency", cyc - last_done_cyc, 1);
    end
    if (go_o != 5'b0) begin
      chk("go_onehot", $countones(go_o), 1);
      if (first_pend) begin
        chk("first_go_latency", cyc - start_cyc, 1);
        chk("busy_at_first_go", int'(busy_o), 1);
        first_pend = 1'b0;
      end
      for (int b = 0; b < 5; b++) if (go_o[b]) n_go[b]++;
      if (go_o[3] && ntt_go_cyc < 0) ntt_go_cyc = cyc;
      if (exp_q.size() == 0) chk("go_unexpected", int'(go_o), 0);
      else begin
        mon_s = exp_q.pop_front();
        chk("go_module", int'(go_o), int'(mon_s.go));
        chk("go_idx", int'(idx_o), mon_s.idx);
      end
    end
  end

  initial begin
    int t;
    vt[0] = '{"keygen", 3'b001, 1, 4, 4, 4, 1, 56};
    vt[1] = '{"encap",  3'b010, 1, 4, 5, 2, 1, 52};
    vt[2] = '{"decap",  3'b100, 0, 4, 5, 2, 2, 52};
    rst = 1'b1; start_i = 1'b0; mode_i = 3'b000; inj = '0; silent = '0;
    clear_stats();
    repeat (2) @(negedge clk);
    chk("rst_go", int'(go_o), 0);
    chk("rst_idx", int'(idx_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      clear_stats();
      push_seq(vt[i].mode);
      pulse_start(vt[i].mode, 1'b1);
      wait_end(vt[i].name);
      chk({vt[i].name, "_trng"}, n_go[0], vt[i].g0);
      chk({vt[i].name, "_sampleA"}, n_go[1], vt[i].g1);
      chk({vt[i].name, "_cbd"}, n_go[2], vt[i].g2);
      chk({vt[i].name, "_ntt"}, n_go[3], vt[i].g3);
      chk({vt[i].name, "_hashG"}, n_go[4], vt[i].g4);
      chk({vt[i].name, "_busy_cycles"}, n_busy, vt[i].busy);
    end

    clear_stats();
    pulse_start(3'b110, 1'b0);
    chk("illegal_err", int'(err_o), 1);
    chk("illegal_busy", int'(busy_o), 0);
    repeat (5) @(negedge clk);
    chk("illegal_err_held", int'(err_o), 1);
    chk("illegal_no_go", n_go[0] + n_go[1] + n_go[2] + n_go[3] + n_go[4], 0);
    chk("illegal_busy_cycles", n_busy, 0);
    clear_stats();
    push_seq(3'b001);
    pulse_start(3'b001, 1'b1);
    chk("err_cleared_by_start", int'(err_o), 0);
    wait_end("after_illegal");

    clear_stats();
    silent = 5'b01000;
    push_seq(3'b010);
    pulse_start(3'b010, 1'b1);
    for (t = 0; t < 500 && err_o == 2'd0; t++) @(negedge clk);
    chk("timeout_err", int'(err_o), 2);
    chk("timeout_latency", cyc - ntt_go_cyc, 16);
    chk("timeout_busy", int'(busy_o), 0);
    repeat (3) @(negedge clk);
    chk("timeout_no_done", n_done, 0);
    chk("timeout_ntt_gos", n_go[3], 1);
    exp_q.delete();
    silent = '0;

    clear_stats();
    push_seq(3'b001);
    pulse_start(3'b001, 1'b1);
    @(negedge clk);
    start_i = 1'b1; mode_i = 3'b100;
    @(negedge clk);
    start_i = 1'b0; mode_i = 3'b000;
    for (t = 0; t < 200 && !go_o[1]; t++) @(negedge clk);
    chk("unexp_reached_sampleA", int'(go_o[1]), 1);
    @(negedge clk);
    inj = 5'b01000;
    @(negedge clk);
    inj = '0;
    chk("unexp_err", int'(err_o), 3);
    chk("unexp_busy", int'(busy_o), 0);
    repeat (6) @(negedge clk);
    chk("unexp_no_done", n_done, 0);
    chk("unexp_idle", int'(busy_o), 0);
    chk("unexp_sampleA_gos", n_go[1], 1);
    chk("unexp_hashG_gos", n_go[4], 1);
    exp_q.delete();

    clear_stats();
    push_seq(3'b010);
    pulse_start(3'b010, 1'b1);
    for (t = 0; t < 200 && !(go_o[2] && idx_o == 4'd2); t++) @(negedge clk);
    chk("rstmid_reached_cbd2", int'(go_o[2] && idx_o == 4'd2), 1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_go", int'(go_o), 0);
    chk("rstmid_idx", int'(idx_o), 0);
    chk("rstmid_busy", int'(busy_o), 0);
    chk("rstmid_done", int'(done_o), 0);
    chk("rstmid_err", int'(err_o), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rstmid_no_done", n_done, 0);
    clear_stats();
    push_seq(3'b010);
    pulse_start(3'b010, 1'b1);
    wait_end("after_reset");
    chk("after_reset_trng", n_go[0], 1);
    chk("after_reset_sampleA", n_go[1], 4);
    chk("after_reset_cbd", n_go[2], 5);
    chk("after_reset_ntt", n_go[3], 2);
    chk("after_reset_hashG", n_go[4], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
